tdc_meas_accum: RTL and testbench
=================================

Name: tdc_meas_accum

Overview:
- Post-processing block placed after one or more tdc_top instances, inside the tt_um top.
- On a start request it collects 2**LOG_SAMPLES valid Hamming-weight samples from each of CH channels.
- Per channel it tracks min, max and sum, then derives the average.
- Results leave as a byte stream over a valid/ready handshake, so a multi-channel, multi-sample measurement fits through the 8-bit output pins.

Parameters:
- N, 64, delay-line length; HW_W = $clog2(N)+1 is the per-channel hw width; HW_W must be ≤8.
- CH, 2, number of TDC channels; legal range 1..4.
- LOG_SAMPLES, 4, log2 of samples accumulated per channel; SUM_W = HW_W+LOG_SAMPLES must be ≤16.
- TIMEOUT, 4096, cycles allowed in ACCUM before abort; 0 disables the timeout; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, shared by all logic.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; when low, forces IDLE.
- start  in  1  measurement request; level-sampled, honoured only in IDLE with en high.
- hw  in  CH*HW_W  per-channel Hamming weight; channel k is at [k*HW_W +: HW_W].
- val  in  CH  per-channel sample-valid strobe, one cycle per sample.
- busy  out  1  high in ACCUM and DRAIN.
- done  out  1  one-cycle pulse after the last stream byte is accepted.
- out_data  out  8  stream byte.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.

Behaviour:
- Reset (rst=1 at a clk edge), from any state:
  - state=IDLE; busy=0, done=0, out_valid=0, out_data=0.
  - All accumulators cleared: sum=0, max=0, min={HW_W{1'b1}}, count=0, timeout counter=0, timeout flag=0.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - start=1 and en=1 -> ACCUM next cycle; all per-channel accumulators and the timeout counter are cleared on that edge.
  - val in the start cycle is not sampled.
- ACCUM:
  - Channel k with val[k]=1 and count[k] < 2**LOG_SAMPLES:
    - sum += hw_k, zero-extended to SUM_W.
    - min = lesser of min and hw_k; max = greater of max and hw_k.
    - count++.
  - val[k] on a channel that is already complete is ignored.
  - Channels update independently; simultaneous val on several channels are all taken in the same cycle.
  - Timeout counter increments every ACCUM cycle.
  - Exit to DRAIN on the edge after all channels are complete. The last sample is included.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT before all channels complete: set timeout flag and go to DRAIN. A val arriving in that same cycle is still accumulated.
- DRAIN:
  - Emits 1+5*CH bytes in order.
  - Byte 0 (header) = {timeout_flag, 3'b0, complete_mask[3:0]}; mask bit k=1 iff count[k] == 2**LOG_SAMPLES; unused bits are 0.
  - Then, per channel k=0..CH-1:
    - min, zero-extended;
    - max, zero-extended;
    - avg = sum >> LOG_SAMPLES (truncated, over the nominal sample count even for incomplete channels);
    - sum[7:0];
    - sum[15:8], zero-filled above SUM_W.
  - Incomplete channels report raw register contents. A channel with zero samples reads min=2**HW_W-1, max=0, sum=0.
- Stream handshake:
  - out_valid rises in the first DRAIN cycle.
  - A byte is transferred on a cycle with out_valid & out_ready.
  - out_data must stay stable while out_valid=1 and out_ready=0.
  - The next byte is presented in the cycle after each transfer (out_valid may stay high back-to-back). Maximum throughput is 1 byte/cycle.
  - After the final transfer: out_valid=0, done=1 for exactly one cycle, state -> IDLE.
- Start handling: start while busy is ignored; a new measurement is accepted no earlier than the cycle after done.
- en=0 in ACCUM or DRAIN:
  - Abort to IDLE next edge; out_valid=0, no done pulse.
  - Accumulator contents are don't-care; they are cleared by the next start.
- busy = (state≠IDLE), registered with the state.

Test Plan:
- Four-sample run (N=64, CH=2, LOG_SAMPLES=2, out_ready=1): start, then ch0 hw=10,20,30,40 and ch1 hw=32 ×4 with interleaved val.
  - Stream = 0x03, 0x0A,0x28,0x19,0x64,0x00, 0x20,0x20,0x20,0x80,0x00; done pulses once; busy then drops.
- Full-scale sample: ch0 hw=64 ×4 with simultaneous val on both channels every cycle.
  - ch0 bytes = 0x40,0x40,0x40,0x00,0x01; ACCUM lasts exactly 4 cycles.
- Timeout (TIMEOUT=50): ch1 val never asserted, ch0 completes.
  - Header=0x81 after 50 ACCUM cycles; ch1 bytes = 0x7F,0x00,0x00,0x00,0x00.
- Backpressure: out_ready toggled randomly, including held low 10 cycles on byte 3.
  - Every byte is held stable while stalled; the byte sequence is identical to the no-stall run; exactly 11 transfers.
- Reset/abort: rst=1 mid-DRAIN after 4 bytes -> next cycle all outputs 0 and IDLE, with no done.
  - Repeat with en=0 mid-ACCUM -> IDLE, no done.
  - A subsequent start reproduces the first scenario's result exactly.
- start and val in the same cycle, and start while busy:
  - The start-cycle val is excluded from sum.
  - A second start during DRAIN causes no restart; exactly one done pulse.

Source files
------------

// File: rtl/tdc_meas_accum.sv
// Per-channel min/max/sum statistics over 2**LOG_SAMPLES TDC Hamming-weight samples,
// streamed out as 1+5*CH bytes over an 8-bit valid/ready interface.
module tdc_meas_accum #(
  parameter int N           = 64,
  parameter int CH          = 2,
  parameter int LOG_SAMPLES = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          start,
  input  logic [CH*($clog2(N)+1)-1:0]   hw,
  input  logic [CH-1:0]                 val,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int HW_W   = $clog2(N) + 1;
  localparam int SUM_W  = HW_W + LOG_SAMPLES;
  localparam int CNT_W  = LOG_SAMPLES + 1;
  localparam int NSAMP  = 1 << LOG_SAMPLES;
  localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int NBYTES = 1 + 5 * CH;
  localparam int IDX_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [HW_W-1:0]  hw_ch   [CH];
  logic [SUM_W-1:0] sum_q   [CH];
  logic [HW_W-1:0]  min_q   [CH];
  logic [HW_W-1:0]  max_q   [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [15:0]      sum_ext [CH];

  logic [TO_W-1:0]  tcnt_q;
  logic             to_flag_q;
  logic [IDX_W-1:0] idx_q;

  logic [CH-1:0]    take;
  logic [CH-1:0]    complete;
  logic [CH-1:0]    complete_nxt;
  logic [3:0]       mask;
  logic             clear;
  logic             to_hit;
  logic             fin;

  // A channel's count never exceeds NSAMP, so its top bit alone marks completion.
  always_comb begin
    mask = '0;
    for (int k = 0; k < CH; k++) begin
      hw_ch[k]        = hw[k*HW_W +: HW_W];
      sum_ext[k]      = 16'(sum_q[k]);
      complete[k]     = cnt_q[k][LOG_SAMPLES];
      take[k]         = (state_q == S_ACCUM) && val[k] && !complete[k];
      complete_nxt[k] = complete[k] || (take[k] && (cnt_q[k] == CNT_W'(NSAMP - 1)));
      mask[k]         = complete[k];
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    to_hit  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle itself is still part of the previous measurement.
        if (en && start && !done) begin
          state_d = S_ACCUM;
          clear   = 1'b1;
        end
      end
      S_ACCUM: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (&complete_nxt) begin
          state_d = S_DRAIN;
        end else if ((TIMEOUT != 0) && (tcnt_q == TO_W'(TIMEOUT - 1))) begin
          state_d = S_DRAIN;
          to_hit  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (out_ready && (idx_q == IDX_W'(NBYTES - 1))) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done      <= 1'b0;
      tcnt_q    <= '0;
      to_flag_q <= 1'b0;
      idx_q     <= '0;
      // NOTE: the per-channel arrays are real flops, not RAM, so they are reset
      // explicitly; an empty channel must read back min=all-ones, max=0.
      for (int k = 0; k < CH; k++) begin
        sum_q[k] <= '0;
        min_q[k] <= '1;
        max_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      done    <= fin;
      if (clear) begin
        tcnt_q    <= '0;
        to_flag_q <= 1'b0;
        idx_q     <= '0;
        for (int k = 0; k < CH; k++) begin
          sum_q[k] <= '0;
          min_q[k] <= '1;
          max_q[k] <= '0;
          cnt_q[k] <= '0;
        end
      end else if (state_q == S_ACCUM) begin
        tcnt_q <= tcnt_q + 1'b1;
        if (to_hit) to_flag_q <= 1'b1;
        for (int k = 0; k < CH; k++) begin
          if (take[k]) begin
            sum_q[k] <= sum_q[k] + SUM_W'(hw_ch[k]);
            if (hw_ch[k] < min_q[k]) min_q[k] <= hw_ch[k];
            if (hw_ch[k] > max_q[k]) max_q[k] <= hw_ch[k];
            cnt_q[k] <= cnt_q[k] + 1'b1;
          end
        end
      end
      if ((state_q == S_DRAIN) && out_ready) idx_q <= idx_q + 1'b1;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DRAIN);

  // Registers are frozen during DRAIN, so the byte only changes when idx_q advances.
  always_comb begin
    out_data = 8'h00;
    if (state_q == S_DRAIN) begin
      if (idx_q == '0) out_data = {to_flag_q, 3'b000, mask};
      for (int k = 0; k < CH; k++) begin
        if (idx_q == IDX_W'(1 + 5*k)) out_data = 8'(min_q[k]);
        if (idx_q == IDX_W'(2 + 5*k)) out_data = 8'(max_q[k]);
        if (idx_q == IDX_W'(3 + 5*k)) out_data = 8'(sum_q[k] >> LOG_SAMPLES);
        if (idx_q == IDX_W'(4 + 5*k)) out_data = sum_ext[k][7:0];
        if (idx_q == IDX_W'(5 + 5*k)) out_data = sum_ext[k][15:8];
      end
    end
  end

endmodule

// File: tb/tb_tdc_meas_accum.sv
// Self-checking bench for tdc_meas_accum: sample-list reference model checked every
// cycle, plus literal stream expectations for the hand-computed scenarios.
module tb_tdc_meas_accum;

  localparam int N    = 64;
  localparam int CH   = 2;
  localparam int LS   = 2;
  localparam int TMO  = 50;
  localparam int HW_W = $clog2(N) + 1;
  localparam int NS   = 1 << LS;
  localparam int NB   = 1 + 5 * CH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 start;
  logic [CH*HW_W-1:0]   hw;
  logic [CH-1:0]        val;
  logic                 busy;
  logic                 done;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;

  tdc_meas_accum #(.N(N), .CH(CH), .LOG_SAMPLES(LS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .hw(hw), .val(val),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal streams: basic run (11), full-scale ch0 (5), timed-out ch1 (5).
  int lit [21] = '{'h03, 'h0A, 'h28, 'h19, 'h64, 'h00, 'h20, 'h20, 'h20, 'h80, 'h00,
                   'h40, 'h40, 'h40, 'h00, 'h01,
                   'h7F, 'h00, 'h00, 'h00, 'h00};
  int pat_v  [7] = '{1, 2, 3, 0, 1, 2, 3};
  int pat_h0 [7] = '{10, 0, 20, 0, 30, 0, 40};
  int pat_h1 [7] = '{0, 32, 32, 0, 0, 32, 32};

  // Reference model: a measurement is the list of accepted samples per channel;
  // the expected stream is derived from those lists when the drain begins.
  int  m_mode = 0;  // 0 idle, 1 accumulating, 2 draining
  bit  m_done = 0;
  bit  m_to   = 0;
  int  m_acyc = 0;
  int  m_ptr  = 0;
  int  samp [CH][NS];
  int  ns   [CH];
  int  exp_b [NB];

  function automatic void build_bytes();
    int mask = 0;
    for (int k = 0; k < CH; k++) if (ns[k] == NS) mask += (1 << k);
    exp_b[0] = (m_to ? 128 : 0) + mask;
    for (int k = 0; k < CH; k++) begin
      int mn = (1 << HW_W) - 1;
      int mx = 0;
      int s  = 0;
      for (int i = 0; i < ns[k]; i++) begin
        if (samp[k][i] < mn) mn = samp[k][i];
        if (samp[k][i] > mx) mx = samp[k][i];
        s += samp[k][i];
      end
      exp_b[1 + 5*k] = mn;
      exp_b[2 + 5*k] = mx;
      exp_b[3 + 5*k] = s / NS;
      exp_b[4 + 5*k] = s % 256;
      exp_b[5 + 5*k] = s / 256;
    end
  endfunction

  always @(posedge clk) begin : model
    bit nd;
    bit all_in;
    nd = 1'b0;
    if (rst) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (en && start && !m_done) begin
             m_mode = 1;
             m_acyc = 0;
             m_to   = 1'b0;
             for (int k = 0; k < CH; k++) ns[k] = 0;
           end
        1: if (!en) begin
             m_mode = 0;
           end else begin
             m_acyc++;
             for (int k = 0; k < CH; k++) begin
               if (val[k] && ns[k] < NS) begin
                 samp[k][ns[k]] = int'(hw[k*HW_W +: HW_W]);
                 ns[k]++;
               end
             end
             all_in = 1'b1;
             for (int k = 0; k < CH; k++) if (ns[k] < NS) all_in = 1'b0;
             if (all_in || m_acyc == TMO) begin
               m_to = !all_in;
               build_bytes();
               m_ptr  = 0;
               m_mode = 2;
             end
           end
        default: if (!en) begin
             m_mode = 0;
           end else if (out_ready) begin
             m_ptr++;
             if (m_ptr == NB) begin
               m_mode = 0;
               nd = 1'b1;
             end
           end
      endcase
    end
    m_done = nd;
  end

  bit   chk_en   = 1'b0;
  bit   hold_q   = 1'b0;
  int   hold_d   = 0;
  int   got [$];
  int   done_cnt = 0;
  int   acc_cyc  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_mode != 0));
      check("out_valid", int'(out_valid), int'(m_mode == 2));
      check("done", int'(done), int'(m_done));
      check("out_data", int'(out_data), (m_mode == 2 && m_ptr < NB) ? exp_b[m_ptr] : 0);
      if (hold_q && out_valid) check("stall_stable", int'(out_data), hold_d);
      hold_q = out_valid && !out_ready;
      hold_d = int'(out_data);
      if (out_valid && out_ready && en && !rst) got.push_back(int'(out_data));
      if (done) done_cnt++;
      if (busy && !out_valid) acc_cyc++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  task automatic check_lit(input string name, input int gbase, input int loff, input int n);
    for (int i = 0; i < n; i++) check(name, got_at(gbase + i), lit[loff + i]);
  endtask

  task automatic rand_hw();
    for (int k = 0; k < CH; k++) hw[k*HW_W +: HW_W] = HW_W'($urandom_range(0, N));
  endtask

  task automatic start_meas(input bit sval);
    start = 1'b1;
    val   = sval ? '1 : '0;
    rand_hw();
    cyc();
    start = 1'b0;
    val   = '0;
  endtask

  task automatic feed_basic();
    for (int i = 0; i < 7; i++) begin
      val = CH'(pat_v[i]);
      hw[0 +: HW_W]    = HW_W'(pat_h0[i]);
      hw[HW_W +: HW_W] = HW_W'(pat_h1[i]);
      cyc();
    end
    val = '0;
  endtask

  // Drains one result; the loop bound turns a missing done into a failed check.
  task automatic wait_done(input bit sdrain, input bit rnd_ready, input bit stall3);
    int base;
    int dc;
    int stall;
    bit stalled;
    base    = got.size();
    dc      = done_cnt;
    stall   = 0;
    stalled = 1'b0;
    for (int i = 0; i < 300 && done_cnt == dc; i++) begin
      start = sdrain && out_valid;
      if (stall3 && !stalled && out_valid && (got.size() - base == 3)) begin
        stall   = 10;
        stalled = 1'b1;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      cyc();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("done_once", done_cnt - dc, 1);
    check("xfer_count", got.size() - base, NB);
  endtask

  task automatic abort_drain(input bit use_rst);
    int base;
    int dc;
    base = got.size();
    dc   = done_cnt;
    start_meas(1'b0);
    feed_basic();
    for (int i = 0; i < 40 && (got.size() - base) < 4; i++) cyc();
    check("abort_after4", got.size() - base, 4);
    if (use_rst) rst = 1'b1;
    else         en  = 1'b0;
    cyc();
    rst = 1'b0;
    en  = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(out_valid), 0);
    check("abort_data", int'(out_data), 0);
    check("abort_done", int'(done), 0);
    idle(12);
    check("abort_no_done", done_cnt - dc, 0);
  endtask

  task automatic rand_run(input int r);
    int dens;
    int abort_at;
    int dc;
    bit aborted;
    dens     = (r % 4 == 3) ? 40 : 2;
    abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : -1;
    dc       = done_cnt;
    aborted  = 1'b0;
    start_meas(1'($urandom_range(0, 1)));
    for (int i = 0; i < 100 && busy && !out_valid; i++) begin
      if (i == abort_at) begin
        en  = 1'b0;
        val = '0;
        cyc();
        en      = 1'b1;
        aborted = 1'b1;
        break;
      end
      for (int k = 0; k < CH; k++) val[k] = ($urandom_range(0, dens) == 0);
      rand_hw();
      cyc();
    end
    val = '0;
    if (aborted) begin
      idle(3);
      check("rand_abort_no_done", done_cnt - dc, 0);
    end else begin
      wait_done(r % 3 == 0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int a0;
    rst = 1'b1; en = 1'b1; start = 1'b0; val = '0; hw = '0; out_ready = 1'b1;
    cyc();
    cyc();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    chk_en = 1'b1;
    rst    = 1'b0;
    idle(2);

    // Basic run: start-cycle val excluded, restart attempts during drain ignored.
    b = got.size();
    start = 1'b1;
    val   = '1;
    hw    = {HW_W'(99), HW_W'(99)};
    cyc();
    start = 1'b0;
    feed_basic();
    check("basic_in_drain", int'(out_valid), 1);
    wait_done(1'b1, 1'b0, 1'b0);
    check_lit("basic_stream", b, 0, 11);
    check("basic_idle_after", int'(busy), 0);

    // Full-scale channel 0 with both channels valid every cycle.
    b  = got.size();
    a0 = acc_cyc;
    start_meas(1'b0);
    for (int i = 0; i < 4; i++) begin
      val = '1;
      hw[0 +: HW_W]    = HW_W'(64);
      hw[HW_W +: HW_W] = HW_W'($urandom_range(0, N));
      cyc();
    end
    val = '0;
    check("fs_accum_cycles", acc_cyc - a0, 4);
    wait_done(1'b0, 1'b0, 1'b0);
    check_lit("fs_ch0", b + 1, 11, 5);

    // Timeout: channel 1 never strobes.
    b  = got.size();
    a0 = acc_cyc;
    start_meas(1'b0);
    for (int i = 0; i < 100 && busy && !out_valid; i++) begin
      val    = '0;
      val[0] = (i == 2 || i == 9 || i == 20 || i == 33);
      rand_hw();
      cyc();
    end
    val = '0;
    check("to_accum_cycles", acc_cyc - a0, TMO);
    wait_done(1'b0, 1'b0, 1'b0);
    check("to_header", got_at(b), 'h81);
    check_lit("to_ch1", b + 6, 16, 5);

    // Backpressure with a long stall on byte 3.
    b = got.size();
    start_meas(1'b0);
    feed_basic();
    wait_done(1'b0, 1'b1, 1'b1);
    check_lit("stall_stream", b, 0, 11);

    // Aborts: reset mid-drain, enable low mid-drain, enable low mid-accumulate.
    abort_drain(1'b1);
    abort_drain(1'b0);
    b = done_cnt;
    start_meas(1'b0);
    val = '1;
    rand_hw();
    cyc();
    cyc();
    val = '0;
    en  = 1'b0;
    cyc();
    en = 1'b1;
    check("en_abort_busy", int'(busy), 0);
    idle(10);
    check("en_abort_no_done", done_cnt - b, 0);

    // A fresh start after the aborts reproduces the basic result.
    b = got.size();
    start_meas(1'b1);
    feed_basic();
    wait_done(1'b0, 1'b0, 1'b0);
    check_lit("rerun_stream", b, 0, 11);

    for (int r = 0; r < 24; r++) rand_run(r);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
